// File: rtl/usb_packet_decoder.sv
// USB full-speed packet decoder: PID check and type decode, token CRC5, data CRC16
// with a 2-byte holdback so the trailing CRC bytes never appear on data_out.
module usb_packet_decoder #(
  parameter int MAX_DATA = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_active,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic [3:0] pid,
  output logic [6:0] token_addr,
  output logic [3:0] token_endp,
  output logic [7:0] data_out,
  output logic       data_strobe,
  output logic       done,
  output logic       ok,
  output logic [2:0] err
);

  localparam int            PW        = $clog2(MAX_DATA + 1);
  localparam logic [PW-1:0] PAY_MAX   = PW'(MAX_DATA);
  localparam logic [4:0]    CRC5_RES  = 5'b01100;
  localparam logic [15:0]   CRC16_RES = 16'h800D;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PID, ST_TOK1, ST_TOK2, ST_DATA, ST_HSK, ST_DRAIN
  } state_t;

  typedef enum logic [2:0] {
    E_NONE = 3'd0, E_PID = 3'd1, E_CRC = 3'd2, E_LEN = 3'd3, E_XCVR = 3'd4
  } err_t;

  // Serial CRCs unrolled over one byte, bits taken LSB-first as on the wire.
  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = {r[3:0], 1'b0} ^ ((r[4] ^ d[i]) ? 5'h05 : 5'h00);
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h8005 : 16'h0000);
    return r;
  endfunction

  state_t        state, state_n;
  err_t          err_q, err_n, fin_err;
  logic [1:0]    cnt, cnt_n;
  logic [4:0]    crc5, crc5_n;
  logic [15:0]   crc16, crc16_n;
  logic [7:0]    tok_lo, tok_lo_n;
  logic [2:0]    tok_hi, tok_hi_n;
  logic [7:0]    buf0, buf0_n, buf1, buf1_n;
  logic [PW-1:0] pay_cnt, pay_n;
  logic [3:0]    pid_n;
  logic          emit;
  logic          rx_active_q;

  // Effect of this cycle's byte (or error) on the packet state; the
  // end-of-packet evaluation below looks at these so a byte arriving with
  // the rx_active fall is still counted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_n  = state;
    err_n    = err_q;
    cnt_n    = cnt;
    crc5_n   = crc5;
    crc16_n  = crc16;
    tok_lo_n = tok_lo;
    tok_hi_n = tok_hi;
    buf0_n   = buf0;
    buf1_n   = buf1;
    pay_n    = pay_cnt;
    pid_n    = pid;
    emit     = 1'b0;
    if (state != ST_IDLE) begin
      if (rx_error) begin
        state_n = ST_DRAIN;
        err_n   = E_XCVR;
      end else if (rx_valid) begin
        unique case (state)
          ST_PID: begin
            pid_n = rx_data[3:0];
            if (rx_data[7:4] != ~rx_data[3:0]) begin
              state_n = ST_DRAIN;
              err_n   = E_PID;
            end else begin
              // PID[1:0]: 01 token, 11 data, 10 handshake, 00 special (unsupported)
              unique case (rx_data[1:0])
                2'b01:   state_n = ST_TOK1;
                2'b11:   state_n = ST_DATA;
                2'b10:   state_n = ST_HSK;
                default: begin
                  state_n = ST_DRAIN;
                  err_n   = E_PID;
                end
              endcase
            end
          end
          ST_TOK1: begin
            tok_lo_n = rx_data;
            crc5_n   = crc5_byte(crc5, rx_data);
            cnt_n    = 2'd1;
            state_n  = ST_TOK2;
          end
          ST_TOK2: begin
            if (cnt == 2'd1) begin
              tok_hi_n = rx_data[2:0];
              crc5_n   = crc5_byte(crc5, rx_data);
              cnt_n    = 2'd2;
            end else begin
              state_n = ST_DRAIN;
              err_n   = E_LEN;
            end
          end
          ST_DATA: begin
            crc16_n = crc16_byte(crc16, rx_data);
            if (cnt == 2'd2 && pay_cnt == PAY_MAX) begin
              state_n = ST_DRAIN;
              err_n   = E_LEN;
            end else begin
              emit   = (cnt == 2'd2);
              pay_n  = (cnt == 2'd2) ? pay_cnt + PW'(1) : pay_cnt;
              cnt_n  = (cnt == 2'd2) ? cnt : cnt + 2'd1;
              buf0_n = buf1;
              buf1_n = rx_data;
            end
          end
          ST_HSK: begin
            state_n = ST_DRAIN;
            err_n   = E_LEN;
          end
          default: ;
        endcase
      end
    end

    fin_err = err_n;
    if (err_n == E_NONE) begin
      unique case (state_n)
        ST_PID, ST_TOK1: fin_err = E_LEN;
        ST_TOK2: begin
          if (cnt_n != 2'd2)            fin_err = E_LEN;
          else if (crc5_n != CRC5_RES)  fin_err = E_CRC;
        end
        ST_DATA: begin
          if (cnt_n != 2'd2)            fin_err = E_LEN;
          else if (crc16_n != CRC16_RES) fin_err = E_CRC;
        end
        default: fin_err = E_NONE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      err_q       <= E_NONE;
      cnt         <= 2'd0;
      crc5        <= 5'h1F;
      crc16       <= 16'hFFFF;
      tok_lo      <= 8'h00;
      tok_hi      <= 3'd0;
      buf0        <= 8'h00;
      buf1        <= 8'h00;
      pay_cnt     <= '0;
      pid         <= 4'h0;
      token_addr  <= 7'h00;
      token_endp  <= 4'h0;
      data_out    <= 8'h00;
      data_strobe <= 1'b0;
      done        <= 1'b0;
      ok          <= 1'b0;
      err         <= 3'd0;
      // Held high so a packet already in flight at reset release is not mistaken for a new one.
      rx_active_q <= 1'b1;
    end else begin
      rx_active_q <= rx_active;
      data_strobe <= 1'b0;
      done        <= 1'b0;
      if (state == ST_IDLE) begin
        if (rx_active && !rx_active_q) begin
          state   <= ST_PID;
          err_q   <= E_NONE;
          cnt     <= 2'd0;
          crc5    <= 5'h1F;
          crc16   <= 16'hFFFF;
          pay_cnt <= '0;
        end
      end else begin
        err_q       <= err_n;
        cnt         <= cnt_n;
        crc5        <= crc5_n;
        crc16       <= crc16_n;
        tok_lo      <= tok_lo_n;
        tok_hi      <= tok_hi_n;
        buf0        <= buf0_n;
        buf1        <= buf1_n;
        pay_cnt     <= pay_n;
        pid         <= pid_n;
        data_strobe <= emit;
        if (emit) data_out <= buf0;
        if (!rx_active) begin
          state <= ST_IDLE;
          done  <= 1'b1;
          err   <= fin_err;
          ok    <= (fin_err == E_NONE);
          if (fin_err == E_NONE && state_n == ST_TOK2) begin
            token_addr <= tok_lo_n[6:0];
            token_endp <= {tok_hi_n, tok_lo_n[7]};
          end
        end else begin
          state <= state_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_packet_decoder.sv
// Scoreboard bench for usb_packet_decoder: directed packets push expected strobes
// and done status; a negedge monitor pops and compares whatever the DUTs present.
module tb_usb_packet_decoder;

  logic clk = 1'b0;
  always #21 clk = ~clk;

  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_active_a, rx_active_b, rx_valid, rx_error;

  logic [3:0] a_pid, b_pid, a_endp, b_endp;
  logic [6:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       a_stb, b_stb, a_done, b_done, a_ok, b_ok;
  logic [2:0] a_err, b_err;

  usb_packet_decoder #(.MAX_DATA(64)) dut_a (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_active(rx_active_a),
    .rx_valid(rx_valid), .rx_error(rx_error), .pid(a_pid), .token_addr(a_addr),
    .token_endp(a_endp), .data_out(a_data), .data_strobe(a_stb), .done(a_done),
    .ok(a_ok), .err(a_err)
  );

  usb_packet_decoder #(.MAX_DATA(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_active(rx_active_b),
    .rx_valid(rx_valid), .rx_error(rx_error), .pid(b_pid), .token_addr(b_addr),
    .token_endp(b_endp), .data_out(b_data), .data_strobe(b_stb), .done(b_done),
    .ok(b_ok), .err(b_err)
  );

  typedef struct {
    bit         is_done;
    logic [7:0] data;
    logic [2:0] err;
    bit         chk_pid;
    logic [3:0] pid;
    bit         chk_tok;
    logic [6:0] addr;
    logic [3:0] endp;
  } exp_t;

  exp_t exp_q [2][$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic void exp_strobe(input int k, input logic [7:0] d);
    exp_t e;
    e = '{default: '0};
    e.data = d;
    exp_q[k].push_back(e);
  endfunction

  function automatic void exp_done(input int k, input logic [2:0] er, input bit cp,
                                   input logic [3:0] p, input bit ct,
                                   input logic [6:0] ad, input logic [3:0] ep);
    exp_t e;
    e = '{default: '0};
    e.is_done = 1'b1;
    e.err     = er;
    e.chk_pid = cp;
    e.pid     = p;
    e.chk_tok = ct;
    e.addr    = ad;
    e.endp    = ep;
    exp_q[k].push_back(e);
  endfunction

  task automatic observe(input int k, input logic stb, input logic [7:0] dout,
                         input logic dn, input logic okv, input logic [2:0] errv,
                         input logic [3:0] pidv, input logic [6:0] ad, input logic [3:0] ep);
    exp_t e;
    if (stb) begin
      n_vec++;
      if (exp_q[k].size() == 0) begin
        n_miss++;
        $display("FAIL dut%0d strobe: got unexpected byte 0x%0h, want none", k, dout);
      end else begin
        e = exp_q[k].pop_front();
        if (e.is_done) begin
          n_miss++;
          $display("FAIL dut%0d strobe: got byte 0x%0h, want done", k, dout);
        end else begin
          check($sformatf("dut%0d data_out", k), 32'(dout), 32'(e.data));
        end
      end
    end
    if (dn) begin
      n_vec++;
      if (exp_q[k].size() == 0) begin
        n_miss++;
        $display("FAIL dut%0d done: got unexpected done err=%0d, want none", k, errv);
      end else begin
        e = exp_q[k].pop_front();
        if (!e.is_done) begin
          n_miss++;
          $display("FAIL dut%0d done: got done, want strobe 0x%0h", k, e.data);
        end else begin
          check($sformatf("dut%0d err", k), 32'(errv), 32'(e.err));
          check($sformatf("dut%0d ok", k), 32'(okv), 32'(e.err == 3'd0));
          if (e.chk_pid) check($sformatf("dut%0d pid", k), 32'(pidv), 32'(e.pid));
          if (e.chk_tok) begin
            check($sformatf("dut%0d token_addr", k), 32'(ad), 32'(e.addr));
            check($sformatf("dut%0d token_endp", k), 32'(ep), 32'(e.endp));
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    observe(0, a_stb, a_data, a_done, a_ok, a_err, a_pid, a_addr, a_endp);
    observe(1, b_stb, b_data, b_done, b_ok, b_err, b_pid, b_addr, b_endp);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_active(input int k, input logic v);
    if (k == 0) rx_active_a = v;
    else        rx_active_b = v;
  endtask

  // One packet: rx_active high, bytes spaced 3 cycles apart, optional rx_error
  // pulse after byte index err_after, then rx_active low and a short gap.
  task automatic send(input int k, input logic [7:0] b[$], input int err_after);
    set_active(k, 1'b1);
    tick(); tick();
    foreach (b[i]) begin
      rx_data  = b[i];
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      tick(); tick();
      if (i == err_after) begin
        rx_error = 1'b1;
        tick();
        rx_error = 1'b0;
        tick();
      end
    end
    set_active(k, 1'b0);
    repeat (4) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_error = 1'b0;
    rx_active_a = 1'b0; rx_active_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset pid",         32'(a_pid),  32'h0);
    check("reset token_addr",  32'(a_addr), 32'h0);
    check("reset token_endp",  32'(a_endp), 32'h0);
    check("reset data_out",    32'(a_data), 32'h0);
    check("reset data_strobe", 32'(a_stb),  32'h0);
    check("reset done",        32'(a_done), 32'h0);
    check("reset ok",          32'(a_ok),   32'h0);
    check("reset err",         32'(a_err),  32'h0);
    reset_n = 1'b1;
    tick();

    // Tokens: SETUP addr0/ep0, SETUP addr1/ep0, IN addr0/ep1
    exp_done(0, 3'd0, 1, 4'hD, 1, 7'h00, 4'h0); send(0, '{8'h2D, 8'h00, 8'h10}, -1);
    exp_done(0, 3'd0, 1, 4'hD, 1, 7'h01, 4'h0); send(0, '{8'h2D, 8'h01, 8'hE8}, -1);
    exp_done(0, 3'd0, 1, 4'h9, 1, 7'h00, 4'h1); send(0, '{8'h69, 8'h80, 8'hA0}, -1);
    // Bad CRC5 must not disturb the captured token fields
    exp_done(0, 3'd2, 1, 4'h1, 0, 7'h00, 4'h0); send(0, '{8'hE1, 8'h01, 8'hE9}, -1);
    check("token_addr held after bad token", 32'(a_addr), 32'h00);
    check("token_endp held after bad token", 32'(a_endp), 32'h1);
    exp_done(0, 3'd3, 0, 4'h0, 0, 7'h00, 4'h0); send(0, '{8'h2D, 8'h00}, -1);
    exp_done(0, 3'd3, 0, 4'h0, 0, 7'h00, 4'h0); send(0, '{8'h2D, 8'h00, 8'h10, 8'h00}, -1);

    // Data: SETUP payload, zero-length packet, corrupted ZLP, too short
    exp_strobe(0, 8'h80); exp_strobe(0, 8'h06); exp_strobe(0, 8'h00); exp_strobe(0, 8'h01);
    exp_strobe(0, 8'h00); exp_strobe(0, 8'h00); exp_strobe(0, 8'h40); exp_strobe(0, 8'h00);
    exp_done(0, 3'd0, 1, 4'h3, 0, 7'h00, 4'h0);
    send(0, '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94}, -1);
    exp_done(0, 3'd0, 1, 4'h3, 0, 7'h00, 4'h0); send(0, '{8'hC3, 8'h00, 8'h00}, -1);
    exp_done(0, 3'd2, 1, 4'h3, 0, 7'h00, 4'h0); send(0, '{8'hC3, 8'h00, 8'h01}, -1);
    exp_done(0, 3'd3, 0, 4'h0, 0, 7'h00, 4'h0); send(0, '{8'hC3, 8'h00}, -1);

    // Handshakes and PID faults
    exp_done(0, 3'd0, 1, 4'h2, 0, 7'h00, 4'h0); send(0, '{8'hD2}, -1);
    exp_done(0, 3'd1, 0, 4'h0, 0, 7'h00, 4'h0); send(0, '{8'hD3}, -1);
    exp_done(0, 3'd3, 0, 4'h0, 0, 7'h00, 4'h0); send(0, '{8'hD2, 8'h00}, -1);
    exp_done(0, 3'd1, 0, 4'h0, 0, 7'h00, 4'h0); send(0, '{8'hB4}, -1);

    // Empty packet: rx_active pulse with no bytes
    exp_done(0, 3'd3, 0, 4'h0, 0, 7'h00, 4'h0);
    rx_active_a = 1'b1; repeat (3) tick();
    rx_active_a = 1'b0; repeat (4) tick();

    // Transceiver error mid DATA1, and overriding a pending length error
    exp_strobe(0, 8'h11);
    exp_done(0, 3'd4, 0, 4'h0, 0, 7'h00, 4'h0);
    send(0, '{8'h4B, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 3);
    exp_done(0, 3'd4, 0, 4'h0, 0, 7'h00, 4'h0); send(0, '{8'hD2, 8'h00}, 1);

    // Payload overflow on the MAX_DATA=4 instance
    exp_strobe(1, 8'h01); exp_strobe(1, 8'h02); exp_strobe(1, 8'h03); exp_strobe(1, 8'h04);
    exp_done(1, 3'd3, 1, 4'h3, 0, 7'h00, 4'h0);
    send(1, '{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hAA, 8'hBB}, -1);

    // Reset mid-packet: no done, outputs cleared, ignore the packet still in flight
    rx_active_a = 1'b1; tick(); tick();
    rx_data = 8'hC3; rx_valid = 1'b1; tick(); rx_valid = 1'b0; tick(); tick();
    rx_data = 8'h11; rx_valid = 1'b1; tick(); rx_valid = 1'b0; tick();
    reset_n = 1'b0; tick();
    check("mid-packet reset pid",        32'(a_pid),  32'h0);
    check("mid-packet reset token_endp", 32'(a_endp), 32'h0);
    reset_n = 1'b1; tick(); tick();
    rx_data = 8'hD2; rx_valid = 1'b1; tick(); rx_valid = 1'b0; tick(); tick();
    rx_active_a = 1'b0; repeat (4) tick();
    check("no packet after reset pid", 32'(a_pid), 32'h0);
    exp_done(0, 3'd0, 1, 4'h2, 0, 7'h00, 4'h0); send(0, '{8'hD2}, -1);

    repeat (5) tick();
    check("dut0 pending expectations", 32'(exp_q[0].size()), 32'd0);
    check("dut1 pending expectations", 32'(exp_q[1].size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
